addsub_rr_arbiter: RTL and testbench

Shares one 4-bit signed add/sub datapath (addsub_4bit, ports sum, ovfl, A, B, sub) between NUM_REQ requesters. A round-robin arbiter grants one requester at a time and latches its operands. The block then drives the shared unit, registers the result and overflow flag, and returns them with a one-cycle acknowledge tagged with the requester ID. It sits between the requesting control units and the single arithmetic slice.

---
 rtl/addsub_rr_arbiter.sv | 93 +++++++++
 tb/tb_addsub_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin sharing of one 4-bit signed add/sub slice among NUM_REQ requesters.
// Build option ADDSUB_SAT_EN saturates overflowing results to +7/-8 instead of wrapping.
module addsub_4bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       sub,
   output logic [3:0] sum,
   output logic       ovfl
);
   assign sum  = sub ? A - B : A + B;
   assign ovfl = (sub ? A[3] != B[3] : A[3] == B[3]) && sum[3] != A[3];
endmodule

module addsub_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [4*NUM_REQ-1:0] a_in,
   input  logic [4*NUM_REQ-1:0] b_in,
   input  logic [NUM_REQ-1:0]   sub_in,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 ack,
   output logic [ID_W-1:0]      ack_id,
   output logic [3:0]           result,
   output logic                 ovfl
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t          r_state, w_next;
   logic [ID_W-1:0] r_ptr, r_win, w_win;
   logic [ID_W:0]   w_idx;
   logic [3:0]      r_a, r_b, w_sum, w_res;
   logic            r_sub, w_ovfl, w_any;
   assign w_any = |req;
   assign busy  = r_state != IDLE;
   // r_ptr is the requester with top priority; the highest offset is scanned first so the lowest wins
   always_comb begin
      w_win = '0;
      w_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(NUM_REQ)) w_idx = w_idx - (ID_W+1)'(NUM_REQ);
         if (req[w_idx[ID_W-1:0]]) w_win = w_idx[ID_W-1:0];
      end
   end
   always_comb begin
      w_next = r_state;
      w_next = r_state == IDLE ? (w_any ? EXEC : IDLE) : r_state == EXEC ? RESP : IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   addsub_4bit u_alu (.A(r_a), .B(r_b), .sub(r_sub), .sum(w_sum), .ovfl(w_ovfl));
`ifdef ADDSUB_SAT_EN
   // on overflow the true sign always equals the sign of A
   assign w_res = w_ovfl ? (r_a[3] ? 4'b1000 : 4'b0111) : w_sum;
`else
   assign w_res = w_sum;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr  <= '0;
         r_win  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_sub  <= 1'b0;
         grant  <= '0;
         ack    <= 1'b0;
         ack_id <= '0;
         result <= '0;
         ovfl   <= 1'b0;
      end else begin
         ack <= r_state == EXEC;
         if (r_state == IDLE && w_any) begin
            r_win <= w_win;
            r_ptr <= w_win == ID_W'(NUM_REQ - 1) ? '0 : w_win + 1'b1;
            r_a   <= a_in[{w_win, 2'b00} +: 4];
            r_b   <= b_in[{w_win, 2'b00} +: 4];
            r_sub <= sub_in[w_win];
            grant <= NUM_REQ'(1) << w_win;
         end
         if (r_state == EXEC) begin
            result <= w_res;
            ovfl   <= w_ovfl;
            ack_id <= r_win;
         end
         if (r_state == RESP) grant <= '0;
      end
   end
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb_addsub_rr_arbiter: directed and randomized checks of addsub_rr_arbiter against a transaction-level model.
module tb_addsub_rr_arbiter;
   localparam int NR = 4;
`ifdef ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [NR-1:0] req = '0, sub_in = '0;
   logic [4*NR-1:0] a_in = '0, b_in = '0;
   logic [NR-1:0] grant;
   logic busy, ack, ovfl;
   logic [1:0] ack_id;
   logic [3:0] result;
   int n_vec = 0, n_err = 0;

   addsub_rr_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .sub_in(sub_in),
      .grant(grant), .busy(busy), .ack(ack), .ack_id(ack_id), .result(result), .ovfl(ovfl));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void alu_ref(input int a, input int b, input bit s, output logic [3:0] r, output logic o);
      int t;
      t = s ? a - b : a + b;
      o = t > 7 || t < -8;
      r = (SAT && o) ? (t > 7 ? 4'b0111 : 4'b1000) : 4'(t);
   endfunction

   logic [NR-1:0] e_grant = '0;
   logic e_busy = 1'b0, e_ack = 1'b0, e_ovfl = 1'b0, m_ov = 1'b0;
   logic [1:0] e_id = '0;
   logic [3:0] e_res = '0, m_res = '0;
   int n_edge = 0, m_last = NR - 1, m_free = 0, m_ack = -10, m_id = 0;

   // operation = grant edge, ack one edge later, next arbitration three edges after grant
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_grant = '0; e_busy = 0; e_ack = 0; e_id = '0; e_res = '0; e_ovfl = 0;
         m_last = NR - 1; m_free = 0; m_ack = -10;
      end else begin
         e_ack = 1'b0;
         if (n_edge == m_ack) begin
            e_ack = 1'b1; e_id = 2'(m_id); e_res = m_res; e_ovfl = m_ov;
         end
         if (n_edge == m_ack + 1) begin
            e_grant = '0; e_busy = 1'b0;
         end
         if (n_edge >= m_free && req != '0) begin
            int w;
            w = -1;
            for (int k = 1; k <= NR; k++)
               if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
            alu_ref(int'($signed(a_in[4*w +: 4])), int'($signed(b_in[4*w +: 4])), sub_in[w], m_res, m_ov);
            m_id = w; m_last = w; m_ack = n_edge + 1; m_free = n_edge + 3;
            e_grant = NR'(1) << w; e_busy = 1'b1;
         end
         n_edge++;
      end
   end

   always @(negedge clk) begin
      check("grant", int'(grant), int'(e_grant));
      check("busy", int'(busy), int'(e_busy));
      check("ack", int'(ack), int'(e_ack));
      check("result", int'(result), int'(e_res));
      check("ovfl", int'(ovfl), int'(e_ovfl));
      if (e_ack) check("ack_id", int'(ack_id), int'(e_id));
   end

   task automatic tick();
      @(negedge clk);
      if (e_ack) req[e_id] = 1'b0;
   endtask

   task automatic set_req(input int i, input int a, input int b, input bit s);
      a_in[4*i +: 4] = 4'(a);
      b_in[4*i +: 4] = 4'(b);
      sub_in[i] = s;
      req[i] = 1'b1;
   endtask

   task automatic wait_ack(input string name, input int id, input int res, input int ov);
      for (int c = 0; c < 20 && !ack; c++) tick();
      check({name, "_seen"}, int'(ack), 1);
      check({name, "_id"}, int'(ack_id), id);
      check({name, "_res"}, int'(result), res);
      check({name, "_ovfl"}, int'(ovfl), ov);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] r;
      logic o;
      int ids[$], cyc[$], res[$];
      int t4_res[4] = '{2, 5, 4, 12};
      alu_ref(7, 1, 0, r, o);
      check("ref_7p1_ovfl", int'(o), 1);
      check("ref_7p1_res", int'(r), SAT ? 7 : 8);
      alu_ref(-3, -5, 1, r, o);
      check("ref_m3m5_res", int'(r), 2);
      check("ref_m3m5_ovfl", int'(o), 0);
      tick();
      tick();
      rst = 1'b0;
      check("rst_grant", int'(grant), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ack", int'(ack), 0);
      check("rst_ack_id", int'(ack_id), 0);
      check("rst_result", int'(result), 0);
      check("rst_ovfl", int'(ovfl), 0);
      set_req(0, 3, 4, 0);
      tick();
      check("t1_grant_exec", int'(grant), 1);
      check("t1_ack_exec", int'(ack), 0);
      tick();
      check("t1_grant_resp", int'(grant), 1);
      check("t1_ack", int'(ack), 1);
      check("t1_id", int'(ack_id), 0);
      check("t1_res", int'(result), 7);
      check("t1_ovfl", int'(ovfl), 0);
      tick();
      check("t1_grant_idle", int'(grant), 0);
      check("t1_busy_idle", int'(busy), 0);
      set_req(1, 7, 1, 0);
      wait_ack("t2", 1, SAT ? 7 : 8, 1);
      tick();
      set_req(2, -8, 1, 1);
      wait_ack("t3a", 2, SAT ? 8 : 7, 1);
      tick();
      set_req(2, -3, -5, 1);
      wait_ack("t3b", 2, 2, 0);
      tick();
      do_reset();
      set_req(0, 1, 1, 0);
      set_req(1, 2, 3, 0);
      set_req(2, 5, 1, 1);
      set_req(3, -2, -2, 0);
      for (int c = 0; c < 40 && ids.size() < 4; c++) begin
         tick();
         if (ack) begin
            ids.push_back(int'(ack_id));
            cyc.push_back(c);
            res.push_back(int'(result));
         end
      end
      check("t4_count", ids.size(), 4);
      foreach (ids[k]) begin
         check("t4_order", ids[k], k);
         check("t4_res", res[k], t4_res[k]);
         if (k > 0) check("t4_gap", cyc[k] - cyc[k-1], 3);
      end
      tick();
      do_reset();
      set_req(1, 1, 2, 0);
      wait_ack("t5a", 1, 3, 0);
      tick();
      set_req(0, 4, 1, 1);
      set_req(2, 2, 2, 0);
      tick();
      check("t5_grant", int'(grant), 4);
      a_in[11:8] = 4'd7;
      wait_ack("t5b", 2, 4, 0);
      tick();
      wait_ack("t5c", 0, 3, 0);
      tick();
      do_reset();
      set_req(3, 1, 2, 0);
      tick();
      check("t6_grant", int'(grant), 8);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_grant", int'(grant), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_ack", int'(ack), 0);
      tick();
      check("t6_rst_noack", int'(ack), 0);
      rst = 1'b0;
      set_req(0, 5, 2, 1);
      wait_ack("t6a", 0, 3, 0);
      tick();
      wait_ack("t6b", 3, 3, 0);
      tick();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int i = 0; i < NR; i++) begin
            if (!req[i] && $urandom_range(3) == 0)
               set_req(i, int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom_range(1)));
            else if (req[i] && !e_grant[i] && $urandom_range(15) == 0)
               req[i] = 1'b0;
            else if ($urandom_range(7) == 0)
               a_in[4*i +: 4] = 4'($urandom_range(15));
         end
      end
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
